// File: rtl/sample_uart_tx_if.sv
// sample_uart_tx_if: sample strobe input and UART/status outputs of the sample transmitter
interface sample_uart_tx_if #(
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_BITS-1:0]        sample_in;
  logic                        sample_valid;
  logic                        tx;
  logic                        busy;
  logic                        overflow;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  modport master (output sample_in, sample_valid, input tx, busy, overflow, fifo_count);
  modport slave (input sample_in, sample_valid, output tx, busy, overflow, fifo_count);
endinterface

// File: rtl/sample_uart_tx.sv
// sample_uart_tx: buffers 16-bit samples in a FIFO and sends each as an 8N1 UART frame of sync, MSB, LSB
module sample_uart_tx #(
  parameter int         DATA_BITS    = 16,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input logic             clk,
  input logic             reset,
  sample_uart_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [1:0]           byte_q, byte_d;
  logic [2:0]           bit_q, bit_d;
  logic [15:0]          baud_q, baud_d;
  logic [7:0]           shift_q, shift_d;
  logic [DATA_BITS-1:0] held_q, held_d;
  logic                 tx_q, tx_d;
  logic                 pop, push, baud_done;
  always_comb begin
    pop        = state_q == IDLE && count_q != '0;
    push       = bus.sample_valid && (count_q != CW'(FIFO_DEPTH) || pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_d       = wr_q + AW'(push);
    rd_d       = rd_q + AW'(pop);
    overflow_d = overflow_q | (bus.sample_valid & ~push);
    baud_done  = baud_q == BAUD_MAX;
    baud_d     = (state_q == IDLE || baud_done) ? '0 : baud_q + 16'd1;
    state_d    = state_q;
    byte_d     = byte_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    held_d     = held_q;
    case (state_q)
      IDLE: if (pop) begin
        held_d  = mem_q[rd_q];
        byte_d  = '0;
        shift_d = SYNC_BYTE;
        state_d = START;
      end
      START: if (baud_done) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (baud_done) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      default: if (baud_done) begin
        state_d = byte_q == 2'd2 ? IDLE : START;
        shift_d = byte_q == 2'd0 ? held_q[DATA_BITS-1 -: 8] : held_q[7:0];
        byte_d  = byte_q == 2'd2 ? 2'd0 : byte_q + 2'd1;
      end
    endcase
    // line level follows the state being entered so tx comes straight from a flop
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      byte_q     <= '0;
      bit_q      <= '0;
      baud_q     <= '0;
      shift_q    <= '0;
      held_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      baud_q     <= baud_d;
      shift_q    <= shift_d;
      held_q     <= held_d;
      tx_q       <= tx_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.sample_in;
  end
  assign bus.tx         = tx_q;
  assign bus.busy       = state_q != IDLE || count_q != '0;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_sample_uart_tx.sv
// tb_sample_uart_tx: random and directed strobes checked against a frame-timing model and a line decoder
module tb_sample_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 30 * CPB;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  sample_uart_tx_if #(.DATA_BITS(16), .FIFO_DEPTH(DEPTH)) bus ();
  sample_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          free_at = 0;
  int          p = 0;
  bit          act = 1'b0;
  bit          m_ovf = 1'b0;
  logic [15:0] w = '0;
  logic [15:0] mq[$];
  logic [7:0]  eq[$];
  bit          rx_act = 1'b0;
  int          rx_off = 0;
  logic [7:0]  rx_b = '0;
  logic [8:0]  rx_exp = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
  endtask
  function automatic logic tx_exp();
    int off = cyc - p;
    int c;
    logic [7:0] b;
    if (!act || off >= FRAME) return 1'b1;
    b = off < 10 * CPB ? 8'hA5 : off < 20 * CPB ? w[15:8] : w[7:0];
    c = (off % (10 * CPB)) / CPB;
    return c == 0 ? 1'b0 : c == 9 ? 1'b1 : b[c-1];
  endfunction
  // the model advances one edge ahead of the DUT, then outputs are compared 1 time unit after that edge
  task automatic step(input logic v, input logic [15:0] d, input logic r);
    bit pop;
    bus.sample_valid = v;
    bus.sample_in = d;
    reset = r;
    cyc++;
    if (r) begin
      mq.delete();
      eq.delete();
      m_ovf = 1'b0;
      act = 1'b0;
      free_at = 0;
    end else begin
      pop = cyc >= free_at && mq.size() > 0;
      if (pop) begin
        w = mq.pop_front();
        p = cyc;
        free_at = cyc + FRAME + 1;
        act = 1'b1;
      end
      if (v) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(d);
          eq.push_back(8'hA5);
          eq.push_back(d[15:8]);
          eq.push_back(d[7:0]);
        end else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("tx", bus.tx, tx_exp());
    chk("fifo_count", bus.fifo_count, mq.size());
    chk("busy", bus.busy, mq.size() > 0 || (act && cyc - p < FRAME));
    chk("overflow", bus.overflow, m_ovf);
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 1'b0);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (reset) rx_act = 1'b0;
      else if (!rx_act) begin
        if (bus.tx === 1'b0) begin
          rx_act = 1'b1;
          rx_off = 0;
        end
      end else begin
        rx_off++;
        if (rx_off == CPB / 2) chk("start_bit", bus.tx, 0);
        else if (rx_off % CPB == CPB / 2 && rx_off < 9 * CPB) rx_b[rx_off/CPB-1] = bus.tx;
        else if (rx_off == 9 * CPB + CPB / 2) begin
          chk("stop_bit", bus.tx, 1);
          if (eq.size() > 0) rx_exp = {1'b1, eq.pop_front()};
          else rx_exp = 9'h000;
          chk("rx_byte", {1'b1, rx_b}, rx_exp);
          rx_act = 1'b0;
        end
      end
    end
  end
  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in = '0;
    repeat (3) step(1'b0, 16'h0, 1'b1);
    idle(100);
    step(1'b1, 16'h1234, 1'b0);
    idle(130);
    step(1'b1, 16'hBEEF, 1'b0);
    step(1'b1, 16'h0001, 1'b0);
    idle(260);
    for (int i = 1; i <= 6; i++) step(1'b1, 16'(i), 1'b0);
    idle(620);
    step(1'b1, 16'hC3C3, 1'b0);
    idle(50);
    step(1'b0, 16'h0, 1'b1);
    idle(5);
    step(1'b1, 16'h00FF, 1'b0);
    idle(130);
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0);
    idle(117);
    step(1'b1, 16'h5A5A, 1'b0);
    chk("full_pop_count", bus.fifo_count, 4);
    chk("full_pop_overflow", bus.overflow, 0);
    idle(620);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 99) < 3, 16'($urandom), $urandom_range(0, 1999) == 0);
    idle(700);
    chk("bytes_left", eq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sample_uart_tx.md
Name: sample_uart_tx

Overview:
Downstream consumer of the CIC decimation filter. It captures each 16-bit decimated sample on a one-cycle valid strobe and buffers it in a small FIFO. Each sample is shipped off-chip as a 3-byte UART frame: sync byte, sample MSB, sample LSB. This lets the tile's filtered ADC output be logged over a single output pin instead of 16 parallel pins.

Parameters:
DATA_BITS, 16, width of the incoming sample; fixed at 16 for 2-byte framing.
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535.
FIFO_DEPTH, 4, number of buffered samples; power of two, at least 2.
SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
sample_in  input  DATA_BITS  decimated sample, valid only when sample_valid=1.
sample_valid  input  1  one-cycle strobe; sample_in is written to the FIFO on this edge.
tx  output  1  UART line, idle high, 8N1, LSB first.
busy  output  1  high while a frame is in flight or the FIFO is non-empty.
overflow  output  1  sticky; set when a sample is dropped because the FIFO is full.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high; all state is evaluated on the rising edge of clk.
- Reset values: tx=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE. FIFO pointers and the bit/byte/baud counters are all 0.
- Reset mid-frame: the frame is aborted. tx is 1 after the reset edge, FIFO contents are discarded, and no partial byte is resumed.
- FIFO write: on an edge with sample_valid=1, the write is accepted if count<FIFO_DEPTH, or if a pop happens on the same edge.
- FIFO overflow: a write that is not accepted drops the sample and sets overflow=1. overflow stays set until reset.
- Occupancy: simultaneous push and pop leaves count unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. Registers: byte_idx 0..2, bit_idx 0..7, baud counter 0..CLKS_PER_BIT-1, shift register 8 bits, held word 16 bits.
- IDLE: tx=1. When count>0, pop the head word into the held register, set byte_idx=0, load the shift register with SYNC_BYTE, and go to START on the same edge.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - byte_idx=0: load held[15:8], byte_idx=1, go to START.
  - byte_idx=1: load held[7:0], byte_idx=2, go to START.
  - byte_idx=2: go to IDLE.
- No idle gap between bytes of a frame.
- Between frames: one idle cycle (the IDLE state) with tx=1 before the next start bit.
- tx is driven from a register (glitch-free).
- Latency: sample_valid at edge E0 into an empty FIFO with the FSM in IDLE gives count=1 after E0. At E1 the word is popped and tx=0 after E1. Worst-case strobe-to-start-bit latency when idle is 2 cycles.
- Frame length: 30*CLKS_PER_BIT cycles, plus 1 idle cycle between back-to-back frames. Default: 480 cycles per frame.
- Throughput: sustained acceptance requires decimation period ≥ 30*CLKS_PER_BIT+1 cycles. Otherwise the FIFO fills and overflow is asserted.
- busy = (state!=IDLE) | (count!=0).
- Sample arithmetic: none. The sample is transmitted bit-exact as two's-complement/unsigned raw bits.

Test Plan:
- Reset sanity: hold reset 3 cycles, then release -> tx=1, busy=0, overflow=0, fifo_count=0. tx stays 1 for 100 idle cycles.
- Single frame (CLKS_PER_BIT=4), sample_in=16'h1234 for 1 cycle:
  - tx=0 starting 2 cycles after the strobe.
  - Decoded bytes A5, 12, 34, each with start=0, stop=1.
  - busy falls after exactly 120 cycles of frame.
- Back-to-back (CLKS_PER_BIT=4), strobes 16'hBEEF then 16'h0001 on consecutive cycles -> fifo_count peaks at 1. Line carries A5 BE EF, one idle cycle, then A5 00 01.
- Overflow (FIFO_DEPTH=4, CLKS_PER_BIT=4), 6 strobes on consecutive cycles with values 1..6:
  - Sample 1 is popped into transmission on the next edge.
  - Samples 2..5 fill the FIFO; sample 6 is dropped.
  - overflow=1 and stays 1. Frames for values 1..5 are sent in order.
- Reset mid-frame: assert reset during the DATA bits of byte 1 -> tx=1 the next cycle and fifo_count=0. A new strobe with 16'h00FF afterwards yields a clean A5 00 FF frame.
- Full-with-pop edge case: FIFO full and the FSM pops on the same edge as sample_valid -> the sample is accepted, count is unchanged, and overflow stays 0.
